spi_master_multi: RTL and testbench
===================================

# spi_master_multi

Parametrised SPI master that generalises the team's fixed 8-bit, single-slave, single-mode SPI controller. It adds configurable word width, SCLK divider, up to NUM_SS chip selects, per-transfer selection of all four SPI modes (CPOL/CPHA), and MSB- or LSB-first shifting. It sits between a local command source (send/send_data handshake) and the off-chip SPI pins, and returns received data with a one-cycle done strobe.

## Interface
- DATA_WIDTH, 8, bits per transfer (>=2)
- NUM_SS, 4, number of slave-select lines (>=1)
- CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
- SS_W, max(1,$clog2(NUM_SS)), derived width of ss_sel

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- send  in  1  transfer request, sampled only while ready=1
- send_data  in  DATA_WIDTH  word to transmit, captured with send
- ss_sel  in  SS_W  target slave index, captured with send
- cpol  in  1  SCLK idle level, captured with send
- cpha  in  1  0: sample leading / shift trailing; 1: shift leading / sample trailing
- lsb_first  in  1  1: bit 0 shifted first, captured with send
- ready  out  1  high in IDLE, send accepted
- busy  out  1  transfer in progress (= ~ready)
- done  out  1  one-cycle pulse at transfer completion
- received_data  out  DATA_WIDTH  last completed received word, held until next done
- sclk  out  1  SPI clock
- mosi  out  1  serial data out
- miso  in  1  serial data in
- ss_n  out  NUM_SS  active-low slave selects, one-hot-low during transfer

## Operation
- Reset (async, rst_n=0): state IDLE, ready=1, busy=0, done=0, received_data=0, sclk=0, mosi=0, ss_n=all ones, edge/bit counters=0. Reset mid-transfer aborts immediately; no done.
- States: IDLE -> SETUP -> TRANSFER -> HOLD -> IDLE.
- IDLE: sclk registered from live cpol (follows with 1-cycle lag); mosi=0. On edge with send=1 and ss_sel<NUM_SS: latch send_data, ss_sel, cpol, cpha, lsb_first; go SETUP. send with ss_sel>=NUM_SS is ignored (stays IDLE, no done).
- SETUP: ss_n[ss_sel]=0; if cpha=0, mosi=first bit; lasts CLK_DIV cycles.
- TRANSFER: 2*DATA_WIDTH SCLK edges, one every CLK_DIV cycles. Odd edges = leading, even = trailing. Shift edge drives next bit on mosi (cpha=1: first bit on edge 1); sample edge captures miso into shift register, at the same clk edge that toggles sclk. Shift/sample direction per latched lsb_first.
- HOLD: sclk at latched cpol, mosi held; lasts CLK_DIV cycles; then ss_n=all ones, received_data<=shift register, done=1, go IDLE.
- send while busy ignored; inputs changing mid-transfer have no effect (latched).
- Received word bit order matches transmit order: first-sampled bit lands in MSB (lsb_first=0) or bit 0 (lsb_first=1).

## Timing
- T0 = clk edge accepting send. At T0: ready=0, busy=1, ss_n asserted, (cpha=0) mosi valid.
- SCLK edge k (k=1..2*DATA_WIDTH) at T0 + k*CLK_DIV.
- Completion edge at T0 + (2*DATA_WIDTH+1)*CLK_DIV: done=1 for that cycle, ready=1, ss_n deasserted, received_data valid.
- Earliest next acceptance: the edge following completion; back-to-back transfers have ss_n high >=1 cycle.
- SCLK period = 2*CLK_DIV clk cycles, 50% duty; no glitches on sclk/ss_n (all registered).

## Test plan
- Mode 0, MSB first, DATA_WIDTH=8, CLK_DIV=4, miso looped to mosi, send_data=0xAB, ss_sel=2 -> ss_n=1011 during transfer, 16 sclk edges, done at T0+68, received_data=0xAB.
- All four cpol/cpha combos with slave model returning 0x5C, send 0x3A -> mosi sampled by model =0x3A, received_data=0x5C each mode; sclk idles at cpol.
- lsb_first=1, send 0x01, loopback -> mosi high on first bit only; received_data=0x01.
- send pulses during busy and ss_sel=4 (NUM_SS=4) while idle -> both ignored, exactly one done per accepted transfer.
- rst_n low mid-transfer (after edge 5) -> ss_n=1111, busy=0, sclk=0 immediately; no done; next transfer 0xC3 loopback completes correctly.
- Back-to-back transfers 0x11 then 0xEE with send held high -> two done pulses (2*DW+1)*CLK_DIV+1 cycles apart, received_data 0x11 then 0xEE.

Source files
------------

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: configurable word width, SCLK divider, slave count,
// per-transfer CPOL/CPHA and bit order. One transfer runs
// IDLE -> SETUP -> TRANSFER -> HOLD -> IDLE, with a one-cycle done strobe.
module spi_master_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SS     = 4,
  parameter int CLK_DIV    = 4,
  parameter int SS_W       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] send_data,
  input  logic [SS_W-1:0]       ss_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] received_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_SS-1:0]     ss_n
);

  localparam int EDGES  = 2 * DATA_WIDTH;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(EDGES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  lsb_q;

  logic div_tick;
  logic last_edge;
  logic sample_edge;

  // edge_cnt holds edges already issued, so the upcoming edge is leading when
  // edge_cnt is even; the sample edge is leading for cpha=0, trailing for cpha=1
  assign div_tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_edge   = (edge_cnt == EDGE_W'(EDGES - 1));
  assign sample_edge = (edge_cnt[0] == cpha_q);
  assign busy        = ~ready;

  // Transfer sequencer with all pin-level outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ready         <= 1'b1;
      done          <= 1'b0;
      received_data <= '0;
      sclk          <= 1'b0;
      mosi          <= 1'b0;
      ss_n          <= '1;
      div_cnt       <= '0;
      edge_cnt      <= '0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      lsb_q         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sclk     <= cpol;
          mosi     <= 1'b0;
          div_cnt  <= '0;
          edge_cnt <= '0;
          if (send && (int'(ss_sel) < NUM_SS)) begin
            state  <= SETUP;
            ready  <= 1'b0;
            ss_n   <= ~(NUM_SS'(1) << ss_sel);
            cpol_q <= cpol;
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
            rx_sh  <= '0;
            // cpha=0 presents the first bit now, so it is consumed up front
            if (!cpha) begin
              mosi  <= lsb_first ? send_data[0] : send_data[DATA_WIDTH-1];
              tx_sh <= lsb_first ? (send_data >> 1) : (send_data << 1);
            end else begin
              tx_sh <= send_data;
            end
          end
        end
        SETUP, TRANSFER: begin
          if (div_tick) begin
            div_cnt  <= '0;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + EDGE_W'(1);
            if (sample_edge) begin
              rx_sh <= lsb_q ? {miso, rx_sh[DATA_WIDTH-1:1]}
                             : {rx_sh[DATA_WIDTH-2:0], miso};
            end else if (!last_edge) begin
              mosi  <= lsb_q ? tx_sh[0] : tx_sh[DATA_WIDTH-1];
              tx_sh <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
            end
            state <= last_edge ? HOLD : TRANSFER;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        HOLD: begin
          sclk <= cpol_q;
          if (div_tick) begin
            div_cnt       <= '0;
            ss_n          <= '1;
            received_data <= rx_sh;
            done          <= 1'b1;
            ready         <= 1'b1;
            state         <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi: directed steps plus randomized
// transfers against a mode-aware SPI slave model.
module tb_spi_master_multi;

  localparam int DW   = 8;
  localparam int NSS  = 4;
  localparam int DIV  = 4;
  localparam int SSW  = 3;
  localparam int XFER = (2 * DW + 1) * DIV;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           send = 1'b0;
  logic [DW-1:0]  send_data = '0;
  logic [SSW-1:0] ss_sel = '0;
  logic           cpol = 1'b0;
  logic           cpha = 1'b0;
  logic           lsb_first = 1'b0;
  logic           ready, busy, done, sclk, mosi, miso;
  logic [DW-1:0]  received_data;
  logic [NSS-1:0] ss_n;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int cyc_g = 0;

  logic          loop_en = 1'b0;
  logic          sl_miso = 1'b0;
  logic          sl_cpol = 1'b0, sl_cpha = 1'b0, sl_lsb = 1'b0;
  logic [DW-1:0] sl_word = '0;
  logic          sl_bits[$];
  int            sl_out_idx = 0;
  logic          sl_sel;

  spi_master_multi #(.DATA_WIDTH(DW), .NUM_SS(NSS), .CLK_DIV(DIV), .SS_W(SSW)) dut (
    .clk(clk), .rst_n(rst_n), .send(send), .send_data(send_data), .ss_sel(ss_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .ready(ready), .busy(busy),
    .done(done), .received_data(received_data), .sclk(sclk), .mosi(mosi),
    .miso(miso), .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  assign miso   = loop_en ? mosi : sl_miso;
  assign sl_sel = (ss_n !== '1);

  always @(posedge clk) begin
    cyc_g <= cyc_g + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic logic sl_bit(input int i);
    return sl_lsb ? sl_word[i] : sl_word[DW-1-i];
  endfunction

  // Slave: on select, cpha=0 slaves present bit 0 before the first edge
  always @(posedge sl_sel) begin
    sl_bits.delete();
    sl_out_idx = 0;
    if (!sl_cpha) begin
      sl_miso    = sl_bit(0);
      sl_out_idx = 1;
    end
  end

  // Slave: leading edges move sclk away from idle; sample/shift per cpha
  always @(sclk) begin
    if (sl_sel) begin
      logic lead;
      lead = (sclk !== sl_cpol);
      if (lead != sl_cpha) begin
        sl_bits.push_back(mosi);
      end else if (sl_out_idx < DW) begin
        sl_miso    = sl_bit(sl_out_idx);
        sl_out_idx = sl_out_idx + 1;
      end
    end
  end

  function automatic logic [DW-1:0] slave_word(input logic lsb);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < sl_bits.size() && i < DW; i++) begin
      if (lsb) w[i] = sl_bits[i];
      else     w[DW-1-i] = sl_bits[i];
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer; poke=1 fires extra send pulses while busy
  task automatic run_xfer(input logic [DW-1:0] data, input int sel, input logic pol,
                          input logic pha, input logic lsb, input logic lp,
                          input logic [DW-1:0] sword, input logic poke, input string tag);
    int cyc, edges, dc0;
    logic prev, ss_bad;
    logic [NSS-1:0] exp_ss;
    cpol = pol; cpha = pha; lsb_first = lsb; loop_en = lp;
    sl_cpol = pol; sl_cpha = pha; sl_lsb = lsb; sl_word = sword;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_idle_sclk"}, sclk, pol);
    dc0 = done_cnt;
    send_data = data; ss_sel = SSW'(sel); send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    for (int i = 0; i < NSS; i++) exp_ss[i] = (i != sel);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_ss_n"}, ss_n, exp_ss);
    cyc = 0; edges = 0; prev = sclk; ss_bad = 1'b0;
    while (done !== 1'b1 && cyc < XFER + 20) begin
      @(posedge clk); #1;
      cyc++;
      if (poke) send = (cyc == 10 || cyc == 30);
      if (poke && cyc == 10) send_data = ~data;
      if (sclk !== prev) edges++;
      prev = sclk;
      if (done !== 1'b1 && ss_n !== exp_ss) ss_bad = 1'b1;
    end
    send = 1'b0;
    check({tag, "_latency"}, cyc, XFER);
    check({tag, "_edges"}, edges, 2 * DW);
    check({tag, "_ss_hold"}, ss_bad, 1'b0);
    check({tag, "_rx"}, received_data, lp ? data : sword);
    check({tag, "_ss_idle"}, ss_n, {NSS{1'b1}});
    check({tag, "_ready"}, ready, 1'b1);
    check({tag, "_slave_nbits"}, sl_bits.size(), DW);
    check({tag, "_slave_rx"}, slave_word(lsb), data);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_done_count"}, done_cnt - dc0, 1);
  endtask

  initial begin
    int dc0, n, t1, t2;
    logic prev;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx", received_data, '0);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_ss_n", ss_n, {NSS{1'b1}});
    @(negedge clk) rst_n = 1'b1;

    // Mode 0 loopback to slave 2
    run_xfer(8'hAB, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, "m0_loop");

    // All four modes against a slave answering 0x5C
    for (int m = 0; m < 4; m++)
      run_xfer(8'h3A, m, m[1], m[0], 1'b0, 1'b0, 8'h5C, 1'b0, $sformatf("mode%0d", m));

    // LSB-first single set bit
    run_xfer(8'h01, 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, "lsb01");

    // Sends while busy are ignored
    run_xfer(8'h69, 3, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, "poke");

    // Out-of-range select is ignored
    cpol = 1'b0; cpha = 1'b0; loop_en = 1'b0;
    dc0 = done_cnt;
    @(negedge clk);
    ss_sel = 3'd4; send = 1'b1;
    repeat (3) @(negedge clk);
    send = 1'b0;
    check("badsel_ready", ready, 1'b1);
    check("badsel_ss_n", ss_n, {NSS{1'b1}});
    repeat (XFER + 4) @(negedge clk);
    check("badsel_no_done", done_cnt - dc0, 0);

    // Reset after SCLK edge 5 aborts immediately without done
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; loop_en = 1'b0;
    sl_cpol = 1'b0; sl_cpha = 1'b0; sl_lsb = 1'b0; sl_word = 8'h96;
    repeat (2) @(posedge clk);
    #1;
    send_data = 8'h5A; ss_sel = 3'd0; send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    n = 0; prev = sclk;
    for (int c = 0; c < XFER && n < 5; c++) begin
      @(posedge clk); #1;
      if (sclk !== prev) n++;
      prev = sclk;
    end
    check("rstmid_edges_seen", n, 5);
    dc0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_ss_n", ss_n, {NSS{1'b1}});
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_sclk", sclk, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rstmid_no_done", done_cnt - dc0, 0);
    @(negedge clk) rst_n = 1'b1;
    run_xfer(8'hC3, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, "after_rst");

    // Back-to-back with send held high
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; loop_en = 1'b1;
    sl_cpol = 1'b0; sl_cpha = 1'b0; sl_lsb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_data = 8'h11; ss_sel = 3'd1; send = 1'b1;
    @(posedge clk); #1;
    send_data = 8'hEE;
    n = 0;
    while (done !== 1'b1 && n < XFER + 20) begin @(posedge clk); #1; n++; end
    t1 = cyc_g;
    check("b2b_rx1", received_data, 8'h11);
    @(posedge clk); #1;
    send = 1'b0;
    check("b2b_accept2", busy, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < XFER + 20) begin @(posedge clk); #1; n++; end
    t2 = cyc_g;
    check("b2b_gap", t2 - t1, XFER + 1);
    check("b2b_rx2", received_data, 8'hEE);

    // Randomized transfers
    for (int r = 0; r < 12; r++) begin
      run_xfer(DW'($urandom), $urandom_range(0, NSS - 1), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), DW'($urandom), 1'b0, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
